// File: rtl/tea_pkg.sv
// Shared constants, types and the round mixing function for the TEA decryptor.
package tea_pkg;

    localparam logic [31:0] TEA_DELTA    = 32'h9E3779B9;
    localparam int          TEA_ROUNDS   = 32;
    localparam logic [31:0] TEA_SUM_INIT = 32'hC6EF3720;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tea_dec_state_t;

    // k0 occupies the most significant word so a packed cast of the key bus lines up.
    typedef struct packed {
        logic [31:0] k0;
        logic [31:0] k1;
        logic [31:0] k2;
        logic [31:0] k3;
    } tea_key_t;

    function automatic logic [31:0] tea_mix(
        input logic [31:0] v,
        input logic [31:0] sum,
        input logic [31:0] ka,
        input logic [31:0] kb
    );
        return ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb);
    endfunction

endpackage

// File: rtl/tea_dec_round.sv
// One combinational inverse TEA round: v1 is updated first, then v0 uses the new v1.
module tea_dec_round
    import tea_pkg::*;
(
    input  logic [31:0] v0,
    input  logic [31:0] v1,
    input  logic [31:0] sum,
    input  tea_key_t    key,
    output logic [31:0] new_v0,
    output logic [31:0] new_v1
);

    logic [31:0] v1_upd_s;

    assign v1_upd_s = v1 - tea_mix(v0, sum, key.k2, key.k3);
    assign new_v1   = v1_upd_s;
    assign new_v0   = v0 - tea_mix(v1_upd_s, sum, key.k0, key.k1);

endmodule

// File: rtl/tea_decryptor.sv
// Iterative streaming TEA block decryptor with AXI-Stream style ports.
// Define TEA_DEC_UNROLL2_EN to evaluate two chained rounds per clock.
module tea_decryptor
    import tea_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [127:0] i_key,
    input  logic         i_axis_valid_s,
    output logic         o_axis_ready_s,
    input  logic [63:0]  i_axis_data_s,
    output logic         o_axis_valid_m,
    input  logic         i_axis_ready_m,
    output logic [63:0]  o_axis_data_m
);

`ifdef TEA_DEC_UNROLL2_EN
    localparam int          STEPS    = TEA_ROUNDS / 2;
    localparam logic [31:0] SUM_STEP = TEA_DELTA + TEA_DELTA;
`else
    localparam int          STEPS    = TEA_ROUNDS;
    localparam logic [31:0] SUM_STEP = TEA_DELTA;
`endif
    localparam logic [4:0] LAST_STEP = 5'(STEPS - 1);

    tea_dec_state_t state_r, state_nxt_s;
    logic           ready_r, ready_nxt_s;
    logic           valid_r, valid_nxt_s;
    logic           accept_s, step_s, load_out_s;

    logic [31:0] v0_r, v1_r, sum_r;
    tea_key_t    key_r;
    logic [4:0]  cnt_r;
    logic [63:0] data_r;
    logic [31:0] r0_v0_s, r0_v1_s, step_v0_s, step_v1_s;

    tea_dec_round u_round0 (
        .v0     (v0_r),
        .v1     (v1_r),
        .sum    (sum_r),
        .key    (key_r),
        .new_v0 (r0_v0_s),
        .new_v1 (r0_v1_s)
    );

`ifdef TEA_DEC_UNROLL2_EN
    logic [31:0] sum_mid_s;

    // The second chained round runs with the sum already reduced by one delta.
    assign sum_mid_s = sum_r - TEA_DELTA;

    tea_dec_round u_round1 (
        .v0     (r0_v0_s),
        .v1     (r0_v1_s),
        .sum    (sum_mid_s),
        .key    (key_r),
        .new_v0 (step_v0_s),
        .new_v1 (step_v1_s)
    );
`else
    assign step_v0_s = r0_v0_s;
    assign step_v1_s = r0_v1_s;
`endif

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt_s = state_r;
        ready_nxt_s = 1'b0;
        valid_nxt_s = valid_r;
        accept_s    = 1'b0;
        step_s      = 1'b0;
        load_out_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_axis_valid_s && ready_r) begin
                    accept_s    = 1'b1;
                    state_nxt_s = RUN;
                    ready_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                    ready_nxt_s = 1'b1;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (cnt_r == LAST_STEP) begin
                    state_nxt_s = DONE;
                    valid_nxt_s = 1'b1;
                    load_out_s  = 1'b1;
                end else begin
                    state_nxt_s = RUN;
                    valid_nxt_s = 1'b0;
                end
            end
            DONE: begin
                if (i_axis_ready_m) begin
                    state_nxt_s = IDLE;
                    valid_nxt_s = 1'b0;
                    ready_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = DONE;
                    valid_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                valid_nxt_s = 1'b0;
                ready_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state and handshake flags; ready stays low until the first edge after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= IDLE;
            ready_r <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= ready_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    // Block state, round counter and output holding register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v0_r   <= 32'd0;
            v1_r   <= 32'd0;
            sum_r  <= 32'd0;
            key_r  <= '0;
            cnt_r  <= 5'd0;
            data_r <= 64'd0;
        end else if (accept_s) begin
            v0_r  <= i_axis_data_s[63:32];
            v1_r  <= i_axis_data_s[31:0];
            sum_r <= TEA_SUM_INIT;
            key_r <= tea_key_t'(i_key);
            cnt_r <= 5'd0;
        end else if (step_s) begin
            v0_r  <= step_v0_s;
            v1_r  <= step_v1_s;
            sum_r <= sum_r - SUM_STEP;
            cnt_r <= cnt_r + 5'd1;
            if (load_out_s) begin
                data_r <= {step_v0_s, step_v1_s};
            end
        end
    end

    assign o_axis_ready_s = ready_r;
    assign o_axis_valid_m = valid_r;
    assign o_axis_data_m  = data_r;

endmodule

// File: tb/tb_tea_decryptor.sv
// Scoreboard bench for tea_decryptor: directed blocks, output checked by a separate monitor.
module tb_tea_decryptor;

`ifdef TEA_DEC_UNROLL2_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 32;
`endif

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic [127:0] i_key = 128'd0;
    logic         i_axis_valid_s = 1'b0;
    logic         o_axis_ready_s;
    logic [63:0]  i_axis_data_s = 64'd0;
    logic         o_axis_valid_m;
    logic         i_axis_ready_m = 1'b1;
    logic [63:0]  o_axis_data_m;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    localparam logic [63:0]  KAT_CT  = 64'h41EA3A0A_94BAA940;
    localparam logic [63:0]  RT_PT   = 64'h01234567_89ABCDEF;
    localparam logic [127:0] RT_KEY  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [63:0]  BP_PT   = 64'hDEADBEEF_CAFEF00D;
    localparam logic [127:0] BP_KEY  = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

    tea_decryptor dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_key          (i_key),
        .i_axis_valid_s (i_axis_valid_s),
        .o_axis_ready_s (o_axis_ready_s),
        .i_axis_data_s  (i_axis_data_s),
        .o_axis_valid_m (o_axis_valid_m),
        .i_axis_ready_m (i_axis_ready_m),
        .o_axis_data_m  (o_axis_data_m)
    );

    always #5 i_clk = ~i_clk;

    // Forward TEA, used only to build ciphertexts whose plaintext is known.
    function automatic logic [63:0] tea_enc(input logic [63:0] pt, input logic [127:0] k);
        logic [31:0] v0, v1, sum;
        v0  = pt[63:32];
        v1  = pt[31:0];
        sum = 32'd0;
        for (int i = 0; i < 32; i++) begin
            sum = sum + 32'h9E3779B9;
            v0  = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + sum) ^ ((v1 >> 5) + k[95:64]));
            v1  = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + sum) ^ ((v0 >> 5) + k[31:0]));
        end
        return {v0, v1};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every output handshake must match the oldest expectation.
    always @(negedge i_clk) begin
        if (!i_rst && o_axis_valid_m && i_axis_ready_m) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h with no block pending", o_axis_data_m);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (o_axis_data_m !== e) begin
                    errors++;
                    $display("FAIL plaintext: got %h expected %h", o_axis_data_m, e);
                end
            end
        end
    end

    // Waits for ready_s, then completes the slave handshake on the next edge.
    task automatic accept(input logic [63:0] d, input logic [127:0] k, input bit keep);
        int n;
        i_axis_valid_s = 1'b1;
        i_axis_data_s  = d;
        i_key          = k;
        n = 0;
        while (!o_axis_ready_s && n < 200) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("accept_timeout", {63'd0, o_axis_ready_s}, 64'd1);
        @(posedge i_clk); #1;
        if (!keep) begin
            i_axis_valid_s = 1'b0;
            i_axis_data_s  = 64'hA5A5A5A5_5A5A5A5A;
        end
    endtask

    // Counts edges from acceptance to valid, checking ready_s stays low meanwhile.
    task automatic wait_out(input string name);
        int lat;
        bit ready_seen;
        lat = 0;
        ready_seen = 1'b0;
        while (!o_axis_valid_m && lat < 100) begin
            if (o_axis_ready_s) ready_seen = 1'b1;
            @(posedge i_clk); #1;
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(LAT));
        chk({name, "_ready_s_in_run"}, {63'd0, ready_seen}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rt_ct, bp_ct;
        int n;
        rt_ct = tea_enc(RT_PT, RT_KEY);
        bp_ct = tea_enc(BP_PT, BP_KEY);

        // Reset values
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_ready_s", {63'd0, o_axis_ready_s}, 64'd0);
        chk("rst_valid_m", {63'd0, o_axis_valid_m}, 64'd0);
        chk("rst_data_m", o_axis_data_m, 64'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        chk("idle_ready_s", {63'd0, o_axis_ready_s}, 64'd1);

        // Known answer
        exp_q.push_back(64'd0);
        accept(KAT_CT, 128'd0, 1'b0);
        wait_out("kat");
        @(posedge i_clk); #1;
        chk("kat_valid_drop", {63'd0, o_axis_valid_m}, 64'd0);
        chk("kat_ready_back", {63'd0, o_axis_ready_s}, 64'd1);

        // Round trip through the forward cipher
        exp_q.push_back(RT_PT);
        accept(rt_ct, RT_KEY, 1'b0);
        wait_out("rt");
        @(posedge i_clk); #1;

        // Backpressure: hold ten cycles, handshake on the first ready cycle
        i_axis_ready_m = 1'b0;
        exp_q.push_back(BP_PT);
        accept(bp_ct, BP_KEY, 1'b0);
        wait_out("bp");
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_valid", {63'd0, o_axis_valid_m}, 64'd1);
            chk("bp_hold_data", o_axis_data_m, BP_PT);
            chk("bp_hold_ready_s", {63'd0, o_axis_ready_s}, 64'd0);
            @(posedge i_clk); #1;
        end
        i_axis_ready_m = 1'b1;
        @(posedge i_clk); #1;
        chk("bp_valid_drop", {63'd0, o_axis_valid_m}, 64'd0);
        chk("bp_ready_s_after", {63'd0, o_axis_ready_s}, 64'd1);
        chk("bp_data_kept", o_axis_data_m, BP_PT);

        // Key and data changed during RUN must not matter
        exp_q.push_back(64'd0);
        accept(KAT_CT, 128'd0, 1'b0);
        i_key         = {128{1'b1}};
        i_axis_data_s = 64'hFFFFFFFF_FFFFFFFF;
        wait_out("keystab");
        @(posedge i_clk); #1;

        // Back-to-back with valid_s held high
        exp_q.push_back(64'd0);
        exp_q.push_back(RT_PT);
        accept(KAT_CT, 128'd0, 1'b1);
        i_axis_data_s = rt_ct;
        i_key         = RT_KEY;
        n = 0;
        while (!o_axis_ready_s && n < 200) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("b2b_ready_gap", 64'(n), 64'(LAT + 1));
        @(posedge i_clk); #1;
        i_axis_valid_s = 1'b0;
        chk("b2b_second_accepted", {63'd0, o_axis_ready_s}, 64'd0);
        wait_out("b2b2");
        @(posedge i_clk); #1;

        // Reset mid-run at round 10
        accept(KAT_CT, 128'd0, 1'b0);
        repeat (10) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        #1;
        chk("mid_rst_valid_m", {63'd0, o_axis_valid_m}, 64'd0);
        chk("mid_rst_data_m", o_axis_data_m, 64'd0);
        chk("mid_rst_ready_s", {63'd0, o_axis_ready_s}, 64'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        chk("post_rst_ready_s", {63'd0, o_axis_ready_s}, 64'd1);
        repeat (40) begin
            if (o_axis_valid_m) chk("post_rst_no_output", 64'd1, 64'd0);
            @(posedge i_clk); #1;
        end
        exp_q.push_back(64'd0);
        accept(KAT_CT, 128'd0, 1'b0);
        wait_out("fresh");
        repeat (3) @(posedge i_clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tea_decryptor.md
# tea_decryptor

Streaming TEA (Tiny Encryption Algorithm) block decryptor: the receive-side counterpart of `tea_accelerator`. It accepts one 64-bit ciphertext block on an AXI-Stream-style slave port and applies 32 inverse TEA rounds with the 128-bit key sampled at acceptance. It then presents the 64-bit plaintext on an AXI-Stream-style master port. It is iterative, with one round per clock (two with the unroll option), and sits directly after the encryptor in loopback and link paths.

## Interface
- No parameters. Round count, delta and initial sum are package constants.
- `i_clk` input 1: the single clock. Everything is rising-edge.
- `i_rst` input 1: reset, asynchronous and active-high.
- `i_key` input 128: key, sampled only on slave handshake. Word order: k0=[127:96], k1=[95:64], k2=[63:32], k3=[31:0].
- `i_axis_valid_s` input 1: ciphertext valid.
- `o_axis_ready_s` output 1: ready to accept ciphertext.
- `i_axis_data_s` input 64: ciphertext. v0=[63:32], v1=[31:0].
- `o_axis_valid_m` output 1: plaintext valid.
- `i_axis_ready_m` input 1: downstream ready.
- `o_axis_data_m` output 64: plaintext. v0=[63:32], v1=[31:0].

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: `o_axis_ready_s`=1. On `i_axis_valid_s && o_axis_ready_s`, latch v0, v1, and k0–k3, set sum=TEA_SUM_INIT (0xC6EF3720), clear the round counter, and go to RUN.
  - RUN: `o_axis_ready_s`=0. Each cycle does one round, in this order:
    - v1 -= ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3)
    - v0 -= ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1), using the updated v1
    - sum -= TEA_DELTA (0x9E3779B9)
  - RUN, continued: the counter increments each round. On the edge completing round 32, load `o_axis_data_m`, set `o_axis_valid_m`=1, and go to DONE.
  - DONE: `o_axis_ready_s`=0. Hold `o_axis_data_m` and `o_axis_valid_m` stable until `i_axis_ready_m`=1. On that handshake edge, deassert valid and go to IDLE.
- Arithmetic is 32-bit modulo 2^32. Shifts are logical. Carries are discarded.
- Changes on `i_key` and `i_axis_data_s` after acceptance are ignored.
- `i_axis_ready_m` is ignored outside DONE.
- No new block is accepted in the same cycle as an output handshake. IDLE is always revisited first.

## Timing
- Reset values:
  - `o_axis_ready_s`=0 while `i_rst` is high, then 1 in IDLE.
  - `o_axis_valid_m`=0.
  - `o_axis_data_m`=0.
  - State=IDLE, all internal registers 0.
- Latency: `o_axis_valid_m` rises 32 clock edges after the slave-handshake edge, or 16 with `TEA_DEC_UNROLL2_EN`.
- Maximum throughput: one block per 34 cycles (18 with unroll), given an immediate downstream ready.
- Reset mid-operation (RUN or DONE): abort immediately and return to reset values. No partial output appears.
- `o_axis_data_m` is registered. It holds the last plaintext after the handshake until the next DONE.

## Configuration
- `TEA_DEC_UNROLL2_EN` defined: two chained rounds per cycle. The counter counts 16 steps. Sum decrements by 2×delta per cycle, with the intermediate sum used by the second round.
- `TEA_DEC_UNROLL2_EN` undefined: one round per cycle, 32 steps.
- Results are bit-identical in both builds. Only latency differs.

## Structure
- Package `tea_pkg`:
  - `TEA_DELTA`, `TEA_ROUNDS` (32), `TEA_SUM_INIT`
  - `tea_dec_state_t` enum (IDLE/RUN/DONE)
  - a `tea_key_t` struct of four 32-bit words
- Sub-module `tea_dec_round`: purely combinational single inverse round. Inputs v0, v1, sum and key; outputs new v0, v1. It is instantiated once, or twice chained under `TEA_DEC_UNROLL2_EN`.

## Test plan
- Known answer: key=0, ciphertext 0x41EA3A0A_94BAA940 → plaintext 0x00000000_00000000. Valid rises exactly 32 cycles after acceptance (16 with the macro).
- Round trip: key 0x00112233_44556677_8899AABB_CCDDEEFF, plaintext 0x01234567_89ABCDEF encrypted by `tea_accelerator` and fed in → output 0x01234567_89ABCDEF.
- Backpressure: `i_axis_ready_m`=0 for 10 cycles in DONE → data and valid are held stable. The output handshake happens on the first ready cycle, with ready_s=1 on the following cycle.
- Back-to-back: `i_axis_valid_s` held high with two blocks → `o_axis_ready_s`=0 throughout RUN and DONE. The second block is accepted only after the first output handshake, and both plaintexts are correct.
- Key stability: `i_key` changed to all ones during RUN → output is still the known-answer plaintext.
- Reset mid-run: assert `i_rst` at round 10 → `o_axis_valid_m`=0 and `o_axis_data_m`=0 immediately. After release, ready_s=1 and a fresh known-answer block decrypts correctly.
